top_core: RTL and testbench
===========================

// Module: top_core
// PURPOSE
//  Chip-level test core. An SPI slave, sampled in the clk_i domain, gives an external host
//  word read/write access to a 1 KiB on-chip SRAM and a 32-bit GPIO output register.
//  An optional fetch sequencer streams SRAM words to gpio_o.
//  Used as the bring-up target for the SPI load/readback bench flow.
// PARAMETERS
//  MEM_WORDS   256          SRAM depth in 32-bit words (byte range 0x000..0x3FF)
//  GPIO_ADDR   32'h1000     byte address of the GPIO output register
//  DUMMY_CYC   32           sclk cycles between read address and read data
// PORTS
//  clk_i           in   1   system clock; every flop is on its rising edge
//  rst_ni          in   1   reset, asynchronous active-low
//  fetch_enable_i  in   1   fetch sequencer enable
//  en_ifetch_i     in   1   fetch sequencer qualifier; fetch runs only when both enables are 1
//  spi_sclk        in   1   SPI clock from host, idle low (mode 0)
//  spi_cs          in   1   SPI chip select, active-low
//  spi_sdi0..3     in   1   SPI data in; only sdi0 is used, sdi1..3 are ignored
//  spi_sdo0..3     out  1   SPI data out; sdo0 carries read data, sdo1..3 are tied to 0
//  spi_mode        out  2   2'b00 = standard single-lane; constant
//  gpio_o          out  32  GPIO output
// BEHAVIOUR
//  - spi_sclk, spi_cs and spi_sdi0 pass through 2-flop synchronisers; sclk edges are detected in the clk_i domain.
//  - Host requirement: sclk high and low phases are each >= 3 clk_i periods.
//  - Reset values: gpio_o=0, spi_sdo*=0, spi_mode=0, FSM=IDLE, fetch pc=0, GPIO reg=0.
//  - SRAM contents are not reset.
//  - Framing: sdi0 is sampled on sclk rise, MSB first. sdo0 changes after sclk fall.
//  - FSM states: IDLE -> CMD(8b) -> ADDR(32b) -> WDATA(32b) | DUMMY(DUMMY_CYC) -> RDATA(32b) -> DONE.
//  - cs falling enters CMD. cs rising from any state returns to IDLE within 3 clk_i.
//  - A write is committed only if all 32 data bits were received before cs rose.
//  - cmd 8'h02 (write): after the 32nd data bit, within 2 clk_i, write the word to mem[addr[9:2]].
//    If addr==GPIO_ADDR, load the GPIO register instead.
//  - cmd 8'h0B (read): after the 32nd address bit, latch the addressed word (GPIO reg if addr==GPIO_ADDR).
//    The word is ready before DUMMY ends. The MSB is driven on the sclk fall that ends the last dummy cycle.
//    The next bits follow on each later fall. Once 32 bits are shifted, sdo0 returns to 0.
//  - Out-of-range addresses: any addr>=0x400 other than GPIO_ADDR. Writes are dropped; reads return 0.
//  - addr[1:0] is ignored.
//  - Unknown cmd: the FSM moves to DONE and ignores bits until cs rises; sdo0 stays 0.
//  - Bits arriving in DONE (beyond the frame) are ignored.
//  - Back-to-back frames are supported with cs high >= 3 clk_i between them.
//  - SRAM has a single port. An SPI access has priority; a fetch loses that cycle and retries.
// CONFIGURATION
//  TOP_CORE_FETCH_EN defined: the fetch sequencer is built.
//   - While fetch_enable_i&&en_ifetch_i, each granted clk_i cycle: gpio_o<=mem[pc], pc<=pc+1 mod MEM_WORDS.
//   - When the enable drops, pc holds and gpio_o reverts to the GPIO reg on the next clk_i.
//  TOP_CORE_FETCH_EN undefined: fetch_enable_i/en_ifetch_i are ignored; gpio_o always equals the GPIO reg.
// TESTING
//  1 write 0x02, addr 128, data 128; wait 10 clk; read 0x0B addr 128 -> rd_data==128 (SUCCESS).
//  2 write 0x02 to GPIO_ADDR, data 0xA5A5_0F0F -> gpio_o==0xA5A5_0F0F within 3 clk of frame end;
//    read back -> same value.
//  3 write addr 0x3FC=0xDEAD_BEEF, then cs high after 16 data bits to addr 0x3FC=0 ->
//    read 0x3FC returns 0xDEAD_BEEF.
//  4 read addr 0x800 -> 0x0000_0000; cmd 0x55 -> sdo0 stays 0 for the whole frame; the next valid frame works.
//  5 rst_ni low mid-read -> sdo0=0, gpio_o=0 immediately; after release, test 1 passes again.
//  6 (FETCH_EN) load mem[0..3]=1,2,3,4, assert both enables ->
//    gpio_o reads 1,2,3,4 on successive clocks; drop en_ifetch_i -> gpio_o = GPIO reg.

Source files
------------

// File: rtl/top_core.sv
// ----------------------------------------------------------------------------
// top_core : chip-level bring-up core.
//
// An SPI mode-0 slave, oversampled in the clk_i domain, gives an external host
// 32-bit word read/write access to an on-chip single-port SRAM and to a 32-bit
// GPIO output register. An optional fetch sequencer streams SRAM words to gpio_o.
//
// Frame: cs low, 8-bit cmd, 32-bit byte address, then
//   cmd 8'h02 : 32 write-data bits
//   cmd 8'h0B : DUMMY_CYC dummy cycles, then 32 read-data bits on sdo0
//   other     : rest of frame ignored, sdo0 stays 0
// Data in is sampled on the sclk rise, MSB first. Data out changes after the sclk fall.
// Byte addresses at or above MEM_WORDS*4 are out of range, except GPIO_ADDR:
// writes to them are dropped and reads return 0. addr[1:0] is ignored.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   fetch_enable_i           fetch sequencer enable
//   en_ifetch_i              fetch qualifier (fetch runs only when both enables are 1)
//   spi_sclk, spi_cs         SPI clock (idle low), chip select (active low)
//   spi_sdi0..3              SPI data in (only sdi0 is used)
//   spi_sdo0..3              SPI data out (sdo0 = read data, sdo1..3 tied to 0)
//   spi_mode                 constant 2'b00 (standard single lane)
//   gpio_o                   GPIO output
//
// Build option: define TOP_CORE_FETCH_EN to build the fetch sequencer.
// Without it, the fetch enables are ignored and gpio_o follows the GPIO register.
// ----------------------------------------------------------------------------
module top_core #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] GPIO_ADDR = 32'h0000_1000,
  parameter int          DUMMY_CYC = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        en_ifetch_i,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [1:0]  spi_mode,
  output logic [31:0] gpio_o
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [7:0]  CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DONE
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and sclk / cs edge detection
  // --------------------------------------------------------------------------
  logic [1:0] sclk_sync, cs_sync, sdi_sync;
  logic       sclk_q, cs_q;
  logic       sclk_s, cs_s, sdi_s;
  logic       sclk_rise, sclk_fall, cs_fall;

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware does.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;   // cs idles high: no false frame start out of reset
      sdi_sync  <= 2'b00;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs};
      sdi_sync  <= {sdi_sync[0], spi_sdi0};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign sdi_s     = sdi_sync[1];
  assign sclk_rise =  sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s &  sclk_q;
  assign cs_fall   = ~cs_s   &  cs_q;

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  state_t      state;
  logic [5:0]  cnt;        // bit / cycle counter within the current field
  logic [31:0] sh;         // incoming serial shift register
  logic        is_write;
  logic [29:0] addr_w;     // word address (byte address bits 31:2)
  logic [31:0] wr_data;
  logic        wr_pend;    // one-cycle SRAM/GPIO write request
  logic        rd_pend;    // one-cycle SRAM/GPIO read request
  logic [31:0] tx;         // outgoing read word
  logic [31:0] gpio_reg;

  // Address decode on the latched word address.
  logic          addr_gpio, addr_mem, spi_busy, mem_we;
  logic [AW-1:0] mem_idx;
  logic [AW-1:0] pc;
  logic [31:0]   mem_rd;
  logic [31:0]   mem [MEM_WORDS];

  assign addr_gpio = (addr_w == GPIO_ADDR[31:2]);
  assign addr_mem  = (addr_w[29:AW] == '0);
  assign spi_busy  = wr_pend | rd_pend;
  assign mem_we    = wr_pend & addr_mem & ~addr_gpio;

  // Single SRAM port: the SPI side wins whenever it has a request pending.
  assign mem_idx   = spi_busy ? addr_w[AW-1:0] : pc;
  assign mem_rd    = mem[mem_idx];

  // NOTE: the SRAM array has no reset; its contents are undefined at power-up
  // and survive rst_ni, and a resettable array would not map onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_idx] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sh       <= '0;
      is_write <= 1'b0;
      addr_w   <= '0;
      wr_data  <= '0;
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      tx       <= '0;
      gpio_reg <= '0;
      spi_sdo0 <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;

      // Pending accesses complete regardless of cs so a fully received write
      // still commits when cs rises right after the last bit.
      if (wr_pend && addr_gpio) gpio_reg <= wr_data;
      if (rd_pend) tx <= addr_gpio ? gpio_reg : (addr_mem ? mem_rd : 32'h0);

      if (cs_s) begin
        state    <= S_IDLE;
        cnt      <= '0;
        spi_sdo0 <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: if (cs_fall) begin
            state <= S_CMD;
            cnt   <= '0;
          end
          S_CMD: if (sclk_rise) begin
            sh  <= {sh[30:0], sdi_s};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd7) begin
              cnt      <= '0;
              is_write <= ({sh[6:0], sdi_s} == CMD_WRITE);
              if ({sh[6:0], sdi_s} == CMD_WRITE || {sh[6:0], sdi_s} == CMD_READ)
                state <= S_ADDR;
              else
                state <= S_DONE;
            end
          end
          S_ADDR: if (sclk_rise) begin
            sh  <= {sh[30:0], sdi_s};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              cnt    <= '0;
              addr_w <= sh[30:1];   // byte address bits 31:2; bit 0 arrives last
              if (is_write) begin
                state <= S_WDATA;
              end else begin
                state   <= S_DUMMY;
                rd_pend <= 1'b1;
              end
            end
          end
          S_WDATA: if (sclk_rise) begin
            sh  <= {sh[30:0], sdi_s};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              wr_data <= {sh[30:0], sdi_s};
              wr_pend <= 1'b1;
              state   <= S_DONE;
            end
          end
          // Count dummy rises; the fall closing the last dummy cycle drives the MSB.
          S_DUMMY: begin
            if (sclk_rise && cnt != 6'(DUMMY_CYC)) cnt <= cnt + 6'd1;
            if (sclk_fall && cnt == 6'(DUMMY_CYC)) begin
              spi_sdo0 <= tx[31];
              tx       <= {tx[30:0], 1'b0};
              cnt      <= 6'd1;
              state    <= S_RDATA;
            end
          end
          S_RDATA: if (sclk_fall) begin
            if (cnt == 6'd32) begin
              spi_sdo0 <= 1'b0;
              state    <= S_DONE;
            end else begin
              spi_sdo0 <= tx[31];
              tx       <= {tx[30:0], 1'b0};
              cnt      <= cnt + 6'd1;
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // GPIO output / optional fetch sequencer
  // --------------------------------------------------------------------------
`ifdef TOP_CORE_FETCH_EN
  logic fetch_on;
  assign fetch_on = fetch_enable_i & en_ifetch_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc     <= '0;
      gpio_o <= '0;
    end else if (fetch_on) begin
      // A cycle taken by an SPI access is simply retried next cycle.
      if (!spi_busy) begin
        gpio_o <= mem_rd;
        pc     <= pc + 1'b1;
      end
    end else begin
      gpio_o <= gpio_reg;
    end
  end
`else
  logic unused_fetch;
  assign unused_fetch = fetch_enable_i ^ en_ifetch_i;
  assign pc           = '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gpio_o <= '0;
    else         gpio_o <= gpio_reg;
  end
`endif

  logic unused_sdi;
  assign unused_sdi = spi_sdi1 ^ spi_sdi2 ^ spi_sdi3;

  assign spi_sdo1 = 1'b0;
  assign spi_sdo2 = 1'b0;
  assign spi_sdo3 = 1'b0;
  assign spi_mode = 2'b00;

endmodule

// File: tb/tb_top_core.sv
// ----------------------------------------------------------------------------
// tb_top_core : directed + randomized bench for top_core.
// A word-level reference model (array of SRAM words + GPIO register) predicts
// every read value; the SPI host is driven bit by bit from tasks.
// ----------------------------------------------------------------------------
module tb_top_core;

  localparam int HALF = 5;   // sclk half period in clk_i cycles

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_enable_i = 1'b0;
  logic        en_ifetch_i = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdi0 = 1'b0;
  logic        spi_sdi1 = 1'b0;
  logic        spi_sdi2 = 1'b0;
  logic        spi_sdi3 = 1'b0;
  logic        spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
  logic [1:0]  spi_mode;
  logic [31:0] gpio_o;

  top_core dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_enable_i (fetch_enable_i),
    .en_ifetch_i    (en_ifetch_i),
    .spi_sclk       (spi_sclk),
    .spi_cs         (spi_cs),
    .spi_sdi0       (spi_sdi0),
    .spi_sdi1       (spi_sdi1),
    .spi_sdi2       (spi_sdi2),
    .spi_sdi3       (spi_sdi3),
    .spi_sdo0       (spi_sdo0),
    .spi_sdo1       (spi_sdo1),
    .spi_sdo2       (spi_sdo2),
    .spi_sdo3       (spi_sdo3),
    .spi_mode       (spi_mode),
    .gpio_o         (gpio_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: 256 SRAM words, their written flags, and the GPIO register.
  logic [31:0] ref_mem [256];
  bit          ref_ok  [256];
  logic [31:0] ref_gpio = 32'h0;

  logic [31:0] rd;
  logic        st;
  logic        s_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the address map rules.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if ((a >> 2) == (32'h1000 >> 2)) return ref_gpio;
    if (a < 32'h400)                 return ref_mem[(a >> 2) % 256];
    return 32'h0;
  endfunction

  // One mode-0 sclk cycle; s is sdo0 as seen just before the rising edge.
  task automatic spi_bit(input logic b, output logic s);
    spi_sdi0 = b;
    repeat (HALF) @(negedge clk_i);
    s = spi_sdo0;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk_i);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_begin();
    repeat (3) @(negedge clk_i);
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk_i);
  endtask

  task automatic spi_end();
    spi_sdi0 = 1'b0;
    repeat (HALF) @(negedge clk_i);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  // Shift the top n bits of v, MSB first; any = OR of sampled sdo0.
  task automatic spi_shift(input logic [31:0] v, input int n, output logic any);
    logic s;
    any = 1'b0;
    for (int i = 31; i > 31 - n; i--) begin
      spi_bit(v[i], s);
      any |= s;
    end
  endtask

  // Write frame sending only the first nbits of data; model updates only on full frames.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int nbits);
    logic any;
    spi_begin();
    spi_shift({8'h02, 24'h0}, 8, any);
    spi_shift(a, 32, any);
    spi_shift(d, nbits, any);
    spi_end();
    if (nbits == 32) begin
      if ((a >> 2) == (32'h1000 >> 2)) ref_gpio = d;
      else if (a < 32'h400) begin
        ref_mem[(a >> 2) % 256] = d;
        ref_ok[(a >> 2) % 256]  = 1'b1;
      end
    end
  endtask

  // Read-style frame: cmd, addr, 32 dummy, 32 data, 2 tail cycles.
  // stray reports any sdo0 high outside the 32 data bits.
  task automatic spi_read(input logic [7:0] c, input logic [31:0] a,
                          output logic [31:0] data, output logic stray);
    logic any, s;
    stray = 1'b0;
    spi_begin();
    spi_shift({c, 24'h0}, 8, any);   stray |= any;
    spi_shift(a, 32, any);           stray |= any;
    spi_shift(32'h0, 32, any);       stray |= any;
    for (int i = 31; i >= 0; i--) begin
      spi_bit(1'b0, s);
      data[i] = s;
    end
    spi_shift(32'h0, 2, any);        stray |= any;
    spi_end();
  endtask

  task automatic read_check(input string tag, input logic [31:0] a);
    logic [31:0] d;
    logic        x;
    spi_read(8'h0B, a, d, x);
    check(tag, d, model_read(a));
    check({tag, "_sdo_idle"}, {31'h0, x}, 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    int          idx, kind;

    // ---------------- reset state ----------------
    repeat (4) @(negedge clk_i);
    check("rst_gpio", gpio_o, 32'h0);
    check("rst_sdo", {28'h0, spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0}, 32'h0);
    check("rst_mode", {30'h0, spi_mode}, 32'h0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    // ---------------- 1: write/read word ----------------
    do_write(32'd128, 32'd128, 32);
    repeat (10) @(negedge clk_i);
    read_check("t1_rd128", 32'd128);

    // ---------------- 2: GPIO write and readback ----------------
    do_write(32'h1000, 32'hA5A5_0F0F, 32);
    check("t2_gpio_o", gpio_o, 32'hA5A5_0F0F);
    read_check("t2_gpio_rd", 32'h1000);

    // ---------------- 3: truncated write is dropped ----------------
    do_write(32'h3FC, 32'hDEAD_BEEF, 32);
    do_write(32'h3FC, 32'h0, 16);
    read_check("t3_rd3fc", 32'h3FC);

    // ---------------- 4: out-of-range read, unknown cmd ----------------
    read_check("t4_oor", 32'h800);
    spi_read(8'h55, 32'h3FC, rd, st);
    check("t4_badcmd_data", rd, 32'h0);
    check("t4_badcmd_sdo", {31'h0, st}, 32'h0);
    read_check("t4_after", 32'h3FC);

    // ---------------- 5: reset mid-read ----------------
    spi_begin();
    spi_shift({8'h0B, 24'h0}, 8, st);
    spi_shift(32'h3FC, 32, st);
    spi_shift(32'h0, 32, st);
    repeat (HALF) @(negedge clk_i);
    check("t5_msb", {31'h0, spi_sdo0}, 32'h1);   // MSB of 0xDEADBEEF
    rst_ni = 1'b0;
    #1;
    check("t5_rst_sdo", {31'h0, spi_sdo0}, 32'h0);
    check("t5_rst_gpio", gpio_o, 32'h0);
    ref_gpio = 32'h0;
    spi_cs   = 1'b1;
    spi_sdi0 = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    do_write(32'd128, 32'd128, 32);
    repeat (10) @(negedge clk_i);
    read_check("t5_t1_again", 32'd128);
    check("t5_gpio_after", gpio_o, 32'h0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 255);
      d    = $urandom;
      case (kind)
        0: do_write((32'(idx) << 2) | 32'($urandom_range(0, 3)), d, 32);
        1: begin
          do_write(32'h1000 | 32'($urandom_range(0, 3)), d, 32);
          check("rnd_gpio_o", gpio_o, ref_gpio);
        end
        2: begin
          a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0000_0400;
          do_write(a | (32'(idx) << 2), d, 32);   // aliases a valid index; must be dropped
          if (ref_ok[idx]) read_check("rnd_drop", 32'(idx) << 2);
        end
        default: begin
          if (ref_ok[idx]) a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
          else if ($urandom_range(0, 1) == 1) a = 32'h1000;
          else a = 32'h0000_0400 + (32'($urandom_range(0, 1023)) << 4);
          read_check("rnd_read", a);
        end
      endcase
    end

    // ---------------- 6: fetch sequencer ----------------
    do_write(32'h0, 32'd1, 32);
    do_write(32'h4, 32'd2, 32);
    do_write(32'h8, 32'd3, 32);
    do_write(32'hC, 32'd4, 32);
    do_write(32'h1000, 32'h1234_5678, 32);
`ifdef TOP_CORE_FETCH_EN
    @(negedge clk_i);
    fetch_enable_i = 1'b1;
    en_ifetch_i    = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check("t6_fetch", gpio_o, 32'(k));
    end
    en_ifetch_i = 1'b0;
    @(negedge clk_i);
    check("t6_revert", gpio_o, ref_gpio);
    fetch_enable_i = 1'b0;
`else
    @(negedge clk_i);
    fetch_enable_i = 1'b1;
    en_ifetch_i    = 1'b1;
    repeat (4) @(negedge clk_i);
    check("t6_nofetch", gpio_o, ref_gpio);
    fetch_enable_i = 1'b0;
    en_ifetch_i    = 1'b0;
`endif
    read_check("t6_rd0", 32'h0);
    read_check("t6_rdC", 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
